// File: rtl/spi_rom_reader.sv
// SPI NOR flash burst reader: sends READ (0x03) or FAST_READ (0x0B) plus address,
// then clocks in len+1 bytes in SPI mode 0, presenting each as a one-cycle data_valid pulse.
module spi_rom_reader #(
  parameter int ADDR_W    = 24,
  parameter int LEN_W     = 8,
  parameter int CLK_DIV   = 1,
  parameter int FAST_READ = 0,
  parameter int CS_IDLE   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic [7:0]        data,
  output logic              data_valid,
  output logic              done,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int OUT_W = 8 + ADDR_W;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = 6;
  localparam int GAP_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam logic [7:0] CMD = (FAST_READ != 0) ? 8'h0B : 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic [OUT_W-1:0]   sh_q, sh_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [6:0]         rx_q, rx_d;
  logic [LEN_W-1:0]   bytes_q, bytes_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               last_q, last_d;
  logic [7:0]         data_q, data_d;
  logic               dv_q, dv_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic               active, tick, rise, fall, phase_end, finish, gap_end, accept;
  logic [BIT_W-1:0]   bit_last;

  always_comb begin
    active    = (state_q == S_CMD) || (state_q == S_ADDR) ||
                (state_q == S_DUMMY) || (state_q == S_DATA);
    accept    = (state_q == S_IDLE) && start && !abort;
    tick      = active && (div_q == DIV_W'(CLK_DIV - 1));
    rise      = tick && !sclk_q;
    fall      = tick && sclk_q;
    bit_last  = (state_q == S_ADDR) ? BIT_W'(ADDR_W - 1) : BIT_W'(7);
    phase_end = rise && (bit_q == bit_last);
    // The last byte is already latched; the burst ends on the next falling SCLK edge.
    finish    = (state_q == S_DATA) && last_q && fall;
    gap_end   = (state_q == S_GAP) && (int'(gap_q) + 1 >= CS_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sh_q    <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
      bytes_q <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      bytes_q <= bytes_d;
      len_q   <= len_d;
      last_q  <= last_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CMD;
      S_CMD:   if (phase_end) state_d = S_ADDR;
      S_ADDR:  if (phase_end) state_d = (FAST_READ != 0) ? S_DUMMY : S_DATA;
      S_DUMMY: if (phase_end) state_d = S_DATA;
      S_DATA:  if (finish) state_d = S_GAP;
      S_GAP:   if (gap_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && active) state_d = S_GAP;
  end

  always_comb begin
    div_d   = div_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    rx_d    = rx_q;
    bytes_d = bytes_q;
    len_d   = len_q;
    last_d  = last_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          bytes_d = '0;
          last_d  = 1'b0;
          len_d   = len;
          sh_d    = {CMD, addr};
        end
      end
      S_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_end) begin
          busy_d = 1'b0;
          gap_d  = '0;
        end
      end
      default: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = !sclk_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        // Zeros shift in behind the address, so MOSI idles low through dummy and data.
        if (fall) sh_d = sh_q << 1;
        if (rise) begin
          bit_d = phase_end ? '0 : bit_q + BIT_W'(1);
          if (state_q == S_DATA) begin
            rx_d = {rx_q[5:0], spi_miso};
            if (phase_end) begin
              data_d  = {rx_q, spi_miso};
              dv_d    = 1'b1;
              last_d  = (bytes_q == len_q);
              bytes_d = bytes_q + LEN_W'(1);
            end
          end
        end
        if (finish) begin
          sclk_d = 1'b0;
          cs_n_d = 1'b1;
          done_d = 1'b1;
          gap_d  = '0;
        end
        if (abort) begin
          sclk_d = 1'b0;
          cs_n_d = 1'b1;
          sh_d   = '0;
          dv_d   = 1'b0;
          done_d = 1'b0;
          data_d = data_q;
          last_d = 1'b0;
          gap_d  = '0;
        end
      end
    endcase
  end

  assign busy       = busy_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign done       = done_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = sh_q[OUT_W-1];

endmodule

// File: doc/spi_rom_reader.md
SPI_ROM_READER -- requirements
Module: spi_rom_reader

Interface
REQ-001 SHALL provide parameter ADDR_W, default 24, address bits sent; legal values 24 or 32.
REQ-002 SHALL provide parameter LEN_W, default 8, width of burst-length input.
REQ-003 SHALL provide parameter CLK_DIV, default 1, clk cycles per SCLK half-period; legal values >= 1.
REQ-004 SHALL provide parameter FAST_READ, default 0; 0 = command 0x03 with no dummy bits, 1 = command 0x0B with 8 dummy SCLK cycles.
REQ-005 SHALL provide parameter CS_IDLE, default 2, minimum clk cycles spi_cs_n stays high between transactions.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  request a burst; sampled only in IDLE.
REQ-009 abort  in  1  terminate the current burst.
REQ-010 addr  in  ADDR_W  first byte address, captured on the accepted start.
REQ-011 len  in  LEN_W  byte count minus one, captured on the accepted start.
REQ-012 busy  out  1  high from the cycle after an accepted start until return to IDLE.
REQ-013 data  out  8  last received byte; holds its value between updates.
REQ-014 data_valid  out  1  one-cycle pulse per received byte.
REQ-015 done  out  1  one-cycle pulse on normal burst completion.
REQ-016 spi_cs_n  out  1  flash chip select, active-low.
REQ-017 spi_sclk  out  1  SPI clock, mode 0, idle low.
REQ-018 spi_mosi  out  1  serial command/address out, MSB first.
REQ-019 spi_miso  in  1  serial data in, MSB first.

Function
REQ-020 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, GAP; DUMMY SHALL be entered only when FAST_READ=1.
REQ-021 IDLE: start=1 and abort=0 SHALL capture addr/len, assert spi_cs_n low and busy high on the next cycle, and enter CMD.
REQ-022 start while busy=1 SHALL be ignored; start and abort together in IDLE SHALL be ignored.
REQ-023 Each SCLK cycle SHALL consist of CLK_DIV clk cycles low followed by CLK_DIV clk cycles high; the first rising edge SHALL occur CLK_DIV cycles after spi_cs_n falls.
REQ-024 spi_mosi SHALL be stable before each rising SCLK edge and SHALL change only at the falling edge, or at CS assertion for the first bit.
REQ-025 spi_miso SHALL be sampled in the clk cycle in which spi_sclk goes high.
REQ-026 CMD SHALL shift 8 bits, ADDR SHALL shift ADDR_W bits, DUMMY SHALL clock 8 bits with spi_mosi=0, and DATA SHALL clock 8*(len+1) bits with spi_mosi=0.
REQ-027 After each 8th DATA sample, data SHALL update and data_valid SHALL pulse on the following clk cycle.
REQ-028 After the final byte's data_valid, the FSM SHALL hold spi_sclk low, raise spi_cs_n, pulse done in the same cycle, and enter GAP.
REQ-029 GAP SHALL keep spi_cs_n high for CS_IDLE cycles, then enter IDLE and drop busy.
REQ-030 len = all-ones SHALL yield 2^LEN_W bytes, with no wrap to zero; the address counter is not maintained and the flash auto-increments.
REQ-031 abort in any non-IDLE state SHALL force spi_sclk low and spi_cs_n high on the next cycle and enter GAP; no further data_valid and no done SHALL follow.
REQ-032 A partially shifted byte at abort SHALL be discarded, and data SHALL keep its last value.
REQ-033 Total SCLK rising edges per completed burst SHALL equal 8 + ADDR_W + 8*FAST_READ + 8*(len+1).

Reset
REQ-034 rst_n low SHALL immediately force spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, data_valid=0, data=0x00, and state IDLE, in any state including mid-burst.
REQ-035 After rst_n rises, the first accepted start SHALL be no earlier than the first clk edge with rst_n high.

Verification
REQ-036 Use defaults, a flash model preloaded with byte[i]=i[7:0], start with addr=0x000010 and len=3 -> MOSI bits 0x03 00 00 10, data_valid x4 with data 0x10,0x11,0x12,0x13, done x1, and 64 SCLK rises.
REQ-037 Use FAST_READ=1 and CLK_DIV=2 with the same request -> command 0x0B, 8 dummy clocks, the same 4 bytes, 72 SCLK rises, and each SCLK high/low lasting 2 clk cycles.
REQ-038 Use ADDR_W=32, addr=0x00000100 and len=0 -> 32 address bits 0x00000100, a single data_valid with data 0x00, and done.
REQ-039 Assert abort during the second DATA byte of an 8-byte burst -> cs_n high the next cycle, exactly 1 data_valid total, no done, and busy low after CS_IDLE cycles.
REQ-040 Pulse start while busy, then drive rst_n low mid-ADDR -> the extra start is ignored, all outputs take reset values at once, and a subsequent start runs a correct burst.
